// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, blanking, and a one-strobe
// registered output stage for syncs and gated colour.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_in,
    input  logic       en_i,
    output logic [9:0] x_o,
    output logic [9:0] y_o,
    output logic       de_o,
    output logic       line_o,
    output logic       frame_o,
    input  logic [1:0] r_i,
    input  logic [1:0] g_i,
    input  logic [1:0] b_i,
    output logic [1:0] r_o,
    output logic [1:0] g_o,
    output logic [1:0] b_o,
    output logic       hs_o,
    output logic       vs_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // The counters are 10 bits wide, so neither dimension may exceed 1024 steps.
    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_geometry
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must both be <= 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h;
    logic [9:0] v;
    logic       h_wrap;
    logic       v_wrap;
    logic       hs_raw;
    logic       vs_raw;
    logic       visible;

    always_comb begin
        h_wrap  = (h == H_LAST);
        v_wrap  = (v == V_LAST);
        hs_raw  = (h >= HS_START) && (h <= HS_END);
        vs_raw  = (v >= VS_START) && (v <= VS_END);
        visible = (h < H_VIS) && (v < V_VIS);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            h <= 10'd0;
            v <= 10'd0;
        end else if (en_i) begin
            if (h_wrap) begin
                h <= 10'd0;
                v <= v_wrap ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // Syncs and colour are captured for the current position, so they appear
    // one strobe after the matching x_o/y_o.
    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            hs_o <= ~SYNC_POL;
            vs_o <= ~SYNC_POL;
            r_o  <= 2'd0;
            g_o  <= 2'd0;
            b_o  <= 2'd0;
        end else if (en_i) begin
            hs_o <= hs_raw ? SYNC_POL : ~SYNC_POL;
            vs_o <= vs_raw ? SYNC_POL : ~SYNC_POL;
            r_o  <= visible ? r_i : 2'd0;
            g_o  <= visible ? g_i : 2'd0;
            b_o  <= visible ? b_i : 2'd0;
        end
    end

    // Pulses are suppressed while reset is low, since that edge restarts at (0,0).
    assign line_o  = en_i && rst_in && h_wrap;
    assign frame_o = en_i && rst_in && h_wrap && v_wrap;
    assign x_o     = h;
    assign y_o     = v;
    assign de_o    = visible;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a shrunken raster, checked against a
// linear pixel-index reference model.
module tb_vga_timing_gen;

    localparam int HA  = 16;
    localparam int HFP = 4;
    localparam int HSY = 6;
    localparam int HBP = 6;
    localparam int VA  = 10;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 3;
    localparam bit POL = 1'b0;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FT  = HT * VT;

    logic       clk_i = 1'b0;
    logic       rst_in = 1'b0;
    logic       en_i = 1'b0;
    logic [1:0] r_i = 2'd0;
    logic [1:0] g_i = 2'd0;
    logic [1:0] b_i = 2'd0;
    logic [9:0] x_o;
    logic [9:0] y_o;
    logic       de_o;
    logic       line_o;
    logic       frame_o;
    logic [1:0] r_o;
    logic [1:0] g_o;
    logic [1:0] b_o;
    logic       hs_o;
    logic       vs_o;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .SYNC_POL(POL)
    ) dut (
        .clk_i(clk_i), .rst_in(rst_in), .en_i(en_i),
        .x_o(x_o), .y_o(y_o), .de_o(de_o), .line_o(line_o), .frame_o(frame_o),
        .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .r_o(r_o), .g_o(g_o), .b_o(b_o),
        .hs_o(hs_o), .vs_o(vs_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Reference state: position as a single index into the frame.
    int   pos = 0;
    bit   model_valid = 1'b0;
    logic exp_hs, exp_vs;
    logic [1:0] exp_r, exp_g, exp_b;

    logic obs_line, obs_frame, obs_hs;

    function automatic bit is_visible(int p);
        return ((p % HT) < HA) && ((p / HT) < VA);
    endfunction

    function automatic bit in_hsync(int p);
        int hh = p % HT;
        return (hh >= HA + HFP) && (hh < HA + HFP + HSY);
    endfunction

    function automatic bit in_vsync(int p);
        int vv = p / HT;
        return (vv >= VA + VFP) && (vv < VA + VFP + VSY);
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d (pos %0d)", tag, observed, expected, pos);
        end
    endtask

    // Drive one clock of inputs, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input bit en, input bit rst_n,
                                 input logic [1:0] r, input logic [1:0] g, input logic [1:0] b);
        @(negedge clk_i);
        en_i   = en;
        rst_in = rst_n;
        r_i    = r;
        g_i    = g;
        b_i    = b;
        #1;
        obs_line  = line_o;
        obs_frame = frame_o;
        obs_hs    = hs_o;
        if (model_valid) begin
            checkOutput("x",     int'(x_o),     pos % HT);
            checkOutput("y",     int'(y_o),     pos / HT);
            checkOutput("de",    int'(de_o),    int'(is_visible(pos)));
            checkOutput("line",  int'(line_o),  int'(en && rst_n && (pos % HT == HT - 1)));
            checkOutput("frame", int'(frame_o), int'(en && rst_n && (pos == FT - 1)));
            checkOutput("hs",    int'(hs_o),    int'(exp_hs));
            checkOutput("vs",    int'(vs_o),    int'(exp_vs));
            checkOutput("r",     int'(r_o),     int'(exp_r));
            checkOutput("g",     int'(g_o),     int'(exp_g));
            checkOutput("b",     int'(b_o),     int'(exp_b));
        end
        @(posedge clk_i);
        if (!rst_n) begin
            pos    = 0;
            exp_hs = ~POL;
            exp_vs = ~POL;
            exp_r  = 2'd0;
            exp_g  = 2'd0;
            exp_b  = 2'd0;
            model_valid = 1'b1;
        end else if (en && model_valid) begin
            exp_hs = in_hsync(pos) ? POL : ~POL;
            exp_vs = in_vsync(pos) ? POL : ~POL;
            exp_r  = is_visible(pos) ? r : 2'd0;
            exp_g  = is_visible(pos) ? g : 2'd0;
            exp_b  = is_visible(pos) ? b : 2'd0;
            pos    = (pos + 1) % FT;
        end
    endtask

    initial begin
        int last_line;
        int last_frame;
        int n_lines;
        int n_frames;
        int hs_low;

        $display("[TB] reset and continuous-strobe run");
        repeat (3) applyStimulus(1'b1, 1'b0, 2'd3, 2'd3, 2'd3);

        last_line = -1;
        last_frame = -1;
        n_lines = 0;
        n_frames = 0;
        hs_low = 0;
        for (int k = 0; k < 2 * FT; k++) begin
            applyStimulus(1'b1, 1'b1, 2'd3, 2'd2, 2'd1);
            if (obs_hs == 1'b0) hs_low++;
            if (obs_line) begin
                if (last_line < 0) checkOutput("first_line", k, HT - 1);
                else checkOutput("line_period", k - last_line, HT);
                last_line = k;
                n_lines++;
            end
            if (obs_frame) begin
                if (last_frame < 0) checkOutput("first_frame", k, FT - 1);
                else checkOutput("frame_period", k - last_frame, FT);
                last_frame = k;
                n_frames++;
            end
        end
        checkOutput("line_count", n_lines, 2 * VT);
        checkOutput("frame_count", n_frames, 2);
        checkOutput("hs_low_total", hs_low, 2 * VT * HSY);

        $display("[TB] randomized strobes, colours and resets");
        for (int k = 0; k < 4000; k++) begin
            applyStimulus($urandom_range(3) != 0, $urandom_range(299) != 0,
                          2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)));
        end

        $display("[TB] mid-frame reset");
        while (pos != (VA / 2) * HT + 5) applyStimulus(1'b1, 1'b1, 2'd3, 2'd3, 2'd3);
        applyStimulus(1'b1, 1'b0, 2'd3, 2'd3, 2'd3);
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd3, 2'd3);

        $display("[TB] strobe every third clock");
        last_line = -1;
        n_lines = 0;
        for (int k = 0; k < 3 * FT; k++) begin
            applyStimulus((k % 3) == 0, 1'b1, 2'($urandom_range(3)), 2'd3, 2'($urandom_range(3)));
            if (obs_line) begin
                if (last_line >= 0) checkOutput("gated_line_period", k - last_line, 3 * HT);
                last_line = k;
                n_lines++;
            end
        end
        checkOutput("gated_line_count", n_lines, VT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
